mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_rr_pick.sv | 28 ++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the two-master memory arbiter.
//   state_t        : arbiter FSM states (IDLE, ISSUE, RESP)
//   M0, M1         : master index constants, as carried on grant
//   ERR_RDATA_DEF  : default read data returned by a timed-out transaction
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// mem_arb_rr_pick
// Combinational round-robin pick between two requesters.
// Ports:
//   valid[1:0]  in  : request lines, bit N = master N
//   last_grant  in  : master granted most recently
//   any         out : at least one request present
//   pick        out : index of the master to grant (0 when nothing requested)
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       any,
  output logic       pick
);

  always_comb begin
    any  = |valid;
    pick = M0;
    if (valid[M0] && valid[M1]) begin
      // contention: the master that did not win last time goes first
      pick = ~last_grant;
    end else if (valid[M1]) begin
      pick = M1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-master to one-slave arbiter on the native valid/ready memory bus.
// Round-robin, one outstanding transaction, all outputs registered.
// Optional feature macro: MEM_ARB_TIMEOUT_EN (slave timeout with forced
// error completion and sticky err flag; parameters used only then).
// Ports:
//   clk, resetn                       : clock, async active-low reset
//   m0_/m1_ valid,addr,wdata,wstrb    : master requests (wstrb 0 = read)
//   m0_/m1_ ready,rdata               : one-cycle completion pulse + read data
//   s_valid,s_addr,s_wdata,s_wstrb    : forwarded request to the slave
//   s_ready,s_rdata                   : slave completion + read data
//   grant                             : master owning current/last transaction
//   err                               : sticky timeout flag
//
// state | meaning
// IDLE  | no transaction; arbitrate among sampled requests
// ISSUE | request presented on s_*, waiting for s_ready
// RESP  | granted master's ready pulses for this one cycle
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF
)
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        grant,
  output logic        err
);

  state_t     r_state;
  logic       r_last_grant;
  logic [1:0] w_valid;
  logic       w_any;
  logic       w_pick;

  assign w_valid = {m1_valid, m0_valid};

  mem_arb_rr_pick u_pick (
    .valid      (w_valid),
    .last_grant (r_last_grant),
    .any        (w_any),
    .pick       (w_pick)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  // counter value during the last ISSUE cycle allowed before timeout
  localparam logic [15:0] LP_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_cnt;
  logic        w_timeout;
  assign w_timeout = (r_cnt == LP_LIMIT);
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_last_grant <= M1;  // m0 wins the first tie
      grant        <= M0;
      s_valid      <= 1'b0;
      s_addr       <= '0;
      s_wdata      <= '0;
      s_wstrb      <= '0;
      m0_ready     <= 1'b0;
      m1_ready     <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_cnt        <= '0;
      err          <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            grant        <= w_pick;
            r_last_grant <= w_pick;
            s_valid      <= 1'b1;
            if (w_pick == M1) begin
              s_addr  <= m1_addr;
              s_wdata <= m1_wdata;
              s_wstrb <= m1_wstrb;
            end else begin
              s_addr  <= m0_addr;
              s_wdata <= m0_wdata;
              s_wstrb <= m0_wstrb;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            r_cnt <= '0;
`endif
            r_state <= ISSUE;
          end
        end

        ISSUE: begin
          // s_ready is checked first so it wins over a same-cycle timeout
          if (s_valid && s_ready) begin
            s_valid <= 1'b0;
            if (grant == M0) begin
              m0_rdata <= s_rdata;
              m0_ready <= 1'b1;
            end else begin
              m1_rdata <= s_rdata;
              m1_ready <= 1'b1;
            end
            r_state <= RESP;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (w_timeout) begin
            s_valid <= 1'b0;
            err     <= 1'b1;
            if (grant == M0) begin
              m0_rdata <= ERR_RDATA;
              m0_ready <= 1'b1;
            end else begin
              m1_rdata <= ERR_RDATA;
              m1_ready <= 1'b1;
            end
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
`endif
        end

        RESP: begin
          m0_ready <= 1'b0;
          m1_ready <= 1'b0;
          r_state  <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: directed scenarios followed by
// randomized transactions, compared against a transaction-level model.
// With MEM_ARB_TIMEOUT_EN defined the DUT uses TIMEOUT_CYCLES=8 and the
// timeout scenarios run as well.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        grant;
  logic        err;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .err(err)
  );

  int checks = 0;
  int errors = 0;

  // transaction-level model: pending requests per master, round-robin
  // memory, last delivered read data per master, sticky error flag
  logic        mv [2];
  logic [31:0] ma [2];
  logic [31:0] mw [2];
  logic [3:0]  ms [2];
  logic        mlast;
  logic [31:0] mrd [2];
  logic        merr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_masters();
    m0_valid = mv[0]; m0_addr = ma[0]; m0_wdata = mw[0]; m0_wstrb = ms[0];
    m1_valid = mv[1]; m1_addr = ma[1]; m1_wdata = mw[1]; m1_wstrb = ms[1];
  endtask

  task automatic model_reset();
    mlast = 1'b1;
    mrd[0] = '0; mrd[1] = '0;
    merr = 1'b0;
    mv[0] = 1'b0; mv[1] = 1'b0;
  endtask

  task automatic new_req(input int i);
    mv[i] = 1'b1;
    ma[i] = $urandom;
    mw[i] = $urandom;
    ms[i] = 4'($urandom_range(0, 15));
  endtask

  // Starts at a negedge with the DUT in IDLE; ends at a negedge in IDLE.
  // after_mode for the winner at its ready cycle: 0 drop, 1 new addr, 2 hold.
  task automatic txn(input int wait_n, input logic [31:0] rd, input int after_mode);
    logic win;
    logic [31:0] ea, ew;
    logic [3:0] es;
    win = (mv[0] && mv[1]) ? ~mlast : mv[1];
    mlast = win;
    ea = ma[win]; ew = mw[win]; es = ms[win];
    drive_masters();
    @(posedge clk); @(negedge clk);
    chk("s_valid_rise", 32'(s_valid), 32'd1);
    chk("grant", 32'(grant), 32'(win));
    chk("s_addr", s_addr, ea);
    chk("s_wdata", s_wdata, ew);
    chk("s_wstrb", 32'(s_wstrb), 32'(es));
    for (int k = 0; k < wait_n; k++) begin
      @(posedge clk); @(negedge clk);
      chk("issue_hold_valid", 32'(s_valid), 32'd1);
      chk("issue_hold_addr", s_addr, ea);
      chk("issue_hold_wdata", s_wdata, ew);
      chk("issue_hold_wstrb", 32'(s_wstrb), 32'(es));
      chk("issue_no_ready", 32'({m1_ready, m0_ready}), 32'd0);
    end
    s_ready = 1'b1;
    s_rdata = rd;
    @(posedge clk); @(negedge clk);
    s_ready = 1'b0;
    s_rdata = $urandom;
    mrd[win] = rd;
    chk("resp_s_valid", 32'(s_valid), 32'd0);
    chk("resp_m0_ready", 32'(m0_ready), 32'(win == 1'b0));
    chk("resp_m1_ready", 32'(m1_ready), 32'(win == 1'b1));
    chk("resp_m0_rdata", m0_rdata, mrd[0]);
    chk("resp_m1_rdata", m1_rdata, mrd[1]);
    chk("err", 32'(err), 32'(merr));
    if (after_mode == 0) mv[win] = 1'b0;
    else if (after_mode == 1) ma[win] = ma[win] + 32'(4 * $urandom_range(1, 64));
    drive_masters();
    @(posedge clk); @(negedge clk);
    chk("idle_ready_low", 32'({m1_ready, m0_ready}), 32'd0);
    chk("idle_s_valid", 32'(s_valid), 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    s_ready = 1'b0;
    s_rdata = '0;
    ma[0] = '0; ma[1] = '0; mw[0] = '0; mw[1] = '0; ms[0] = '0; ms[1] = '0;
    model_reset();
    drive_masters();
    repeat (3) @(negedge clk);
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    chk("rst_s_wdata", s_wdata, 32'd0);
    chk("rst_s_wstrb", 32'(s_wstrb), 32'd0);
    chk("rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // both request together after reset: m0 first, then alternating
    new_req(0); new_req(1);
    for (int i = 0; i < 4; i++) begin
      txn(0, $urandom, 2);
      chk("alt_grant", 32'(grant), 32'(i % 2));
    end
    mv[0] = 1'b0; mv[1] = 1'b0;
    drive_masters();
    @(negedge clk);

    // m0 read with two slave wait cycles
    mv[0] = 1'b1; ma[0] = 32'h0000_0100; mw[0] = $urandom; ms[0] = 4'b0000;
    txn(2, 32'h1234_5678, 0);
    chk("t1_m0_rdata", m0_rdata, 32'h1234_5678);

    // m1 byte write; m0 read data must not move
    mv[1] = 1'b1; ma[1] = 32'h1000_0000; mw[1] = 32'h0000_0041; ms[1] = 4'b0001;
    txn(1, $urandom, 0);
    chk("t3_m0_rdata_kept", m0_rdata, 32'h1234_5678);

    // m0 holds valid and moves to a new address after its ready
    mv[0] = 1'b1; ma[0] = 32'h0000_0200; mw[0] = $urandom; ms[0] = 4'b1111;
    txn(0, $urandom, 1);
    txn(1, $urandom, 0);
    repeat (3) begin
      @(negedge clk);
      chk("t4_no_duplicate", 32'(s_valid), 32'd0);
    end

    // async reset while the slave is still being waited on
    new_req(0);
    drive_masters();
    @(posedge clk); @(negedge clk);
    chk("t5_in_issue", 32'(s_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("t5_s_valid_async", 32'(s_valid), 32'd0);
    chk("t5_ready_async", 32'({m1_ready, m0_ready}), 32'd0);
    chk("t5_grant_async", 32'(grant), 32'd0);
    model_reset();
    drive_masters();
    @(negedge clk);
    resetn = 1'b1;
    new_req(1);
    txn(1, $urandom, 0);

    // async reset during the ready pulse: pulse is cut short
    new_req(0);
    drive_masters();
    @(posedge clk); @(negedge clk);
    s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
    @(posedge clk); @(negedge clk);
    s_ready = 1'b0;
    chk("t5b_resp_ready", 32'(m0_ready), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("t5b_ready_async", 32'(m0_ready), 32'd0);
    chk("t5b_rdata_async", m0_rdata, 32'd0);
    model_reset();
    drive_masters();
    @(negedge clk);
    resetn = 1'b1;

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++)
        if (!mv[i] && $urandom_range(0, 1) == 1) new_req(i);
      if (!mv[0] && !mv[1]) new_req(int'($urandom_range(0, 1)));
      txn(int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 1)));
    end
    mv[0] = 1'b0; mv[1] = 1'b0;
    drive_masters();
    @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
    // s_ready arriving in the last allowed ISSUE cycle still completes normally
    new_req(0);
    txn(7, 32'h0BAD_CAFE, 0);
    chk("to_boundary_rdata", m0_rdata, 32'h0BAD_CAFE);

    // slave never answers: forced completion after 8 ISSUE cycles
    new_req(0);
    mlast = 1'b0;
    drive_masters();
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk("to_wait_valid", 32'(s_valid), 32'd1);
      chk("to_wait_ready", 32'(m0_ready), 32'd0);
      @(posedge clk); @(negedge clk);
    end
    chk("to_ready", 32'(m0_ready), 32'd1);
    chk("to_rdata", m0_rdata, ERR_RDATA_DEF);
    chk("to_err", 32'(err), 32'd1);
    chk("to_s_valid", 32'(s_valid), 32'd0);
    mrd[0] = ERR_RDATA_DEF;
    merr = 1'b1;
    mv[0] = 1'b0;
    drive_masters();
    @(posedge clk); @(negedge clk);
    chk("to_err_sticky", 32'(err), 32'd1);
    new_req(1);
    txn(2, $urandom, 0);
`else
    chk("err_tied_low", 32'(err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
